wb_arbiter: RTL and testbench

Write-back arbiter that merges two result streams into the single write port (W/WD/WE) of the 32×32 register file. The in-order pipeline result is the primary source and always wins. The long-latency mul/div result is the secondary source; it is buffered in a small FIFO and drained in free slots. The block also publishes a pending-write mask for hazard detection and a stall request that guarantees the secondary source makes forward progress.

---
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle.
// Groups the primary/secondary request streams, the register-file write port
// (W/WD/WE), hazard/stall outputs, the error flag and the statistics counters.
//   master : request source and observer (pipeline side / testbench)
//   slave  : the arbiter itself
interface wb_arbiter_if;
  logic        pri_valid;
  logic [4:0]  pri_addr;
  logic [31:0] pri_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_addr;
  logic [31:0] sec_data;
  logic [4:0]  W;
  logic [31:0] WD;
  logic        WE;
  logic        stall;
  logic [31:0] busy_mask;
  logic        err;
  logic [15:0] stat_stall;
  logic [15:0] stat_kill;

  modport master (
    output pri_valid, pri_addr, pri_data, sec_valid, sec_addr, sec_data,
    input  sec_ready, W, WD, WE, stall, busy_mask, err, stat_stall, stat_kill
  );

  modport slave (
    input  pri_valid, pri_addr, pri_data, sec_valid, sec_addr, sec_data,
    output sec_ready, W, WD, WE, stall, busy_mask, err, stat_stall, stat_kill
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the in-order pipeline result (primary, always
// wins) and the mul/div result (secondary, buffered in a DEPTH-entry FIFO)
// onto the single register-file write port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus.slave  : primary/secondary requests, registered W/WD/WE, stall,
//                busy_mask (pending secondary writes), sticky err,
//                stat_stall/stat_kill counters.
// Build option: define WB_STATS_EN to build the 16-bit saturating statistics
// counters; otherwise the stat ports are tied to 0.
module wb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned GW   = $clog2(MAX_WAIT + 1);
  localparam int unsigned SW   = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [DEPTH-1:0]  live;
  logic [DEPTH-1:0]  live_nxt;
  logic [DEPTH-1:0]  kill_vec;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [GW-1:0]     age;
  logic [AW-1:0]     w_q;
  logic [DW-1:0]     wd_q;
  logic              we_q;
  logic              we_sec_q;
  logic              err_q;

  entry_t            head;
  logic              head_valid;
  logic              head_live;
  logic              pri_acc;
  logic              enq;
  logic              deq;
  logic              issue_sec;
  logic              sec_ready_c;
  logic              stall_c;
  logic [NREG-1:0]   busy_c;

  // Handshake, issue selection, kill vector and next FIFO state.
  always_comb begin
    head        = mem[rd_ptr];
    head_valid  = (count != '0);
    head_live   = head_valid && live[rd_ptr];
    pri_acc     = bus.pri_valid && (bus.pri_addr != '0);
    sec_ready_c = !rst && (count != CW'(DEPTH));
    enq         = bus.sec_valid && sec_ready_c && (bus.sec_addr != '0);
    issue_sec   = head_live && !pri_acc;
    // A dead head leaves immediately; a live head leaves only when issued.
    deq         = head_valid && (!live[rd_ptr] || !pri_acc);
    stall_c     = (count == CW'(DEPTH)) || (head_live && (age == GW'(MAX_WAIT)));

    for (int i = 0; i < int'(DEPTH); i++) begin
      kill_vec[i] = pri_acc && live[i] && (mem[i].addr == bus.pri_addr);
    end

    // Live is only ever set on occupied slots, so it doubles as occupancy
    // for the kill and busy logic; the enqueue slot is applied after kill.
    live_nxt = live & ~kill_vec;
    if (deq) live_nxt[rd_ptr] = 1'b0;
    if (enq) live_nxt[wr_ptr] = 1'b1;

    case ({enq, deq})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pending-write mask: live FIFO entries plus a secondary write on the port.
  always_comb begin
    busy_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live[i]) busy_c[mem[i].addr] = 1'b1;
    end
    if (we_sec_q) busy_c[w_q] = 1'b1;
    busy_c[0] = 1'b0;
  end

  // FIFO payload storage (no reset needed, guarded by live bits).
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr].addr <= bus.sec_addr;
      mem[wr_ptr].data <= bus.sec_data;
    end
  end

  // Control state, write port and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      age      <= '0;
      w_q      <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      we_sec_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      live  <= live_nxt;
      count <= count_nxt;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);

      if (!head_valid || deq) begin
        age <= '0;
      end else if (head_live && (age != GW'(MAX_WAIT))) begin
        age <= age + GW'(1);
      end

      if (pri_acc) begin
        w_q      <= bus.pri_addr;
        wd_q     <= bus.pri_data;
        we_q     <= 1'b1;
        we_sec_q <= 1'b0;
      end else if (issue_sec) begin
        w_q      <= head.addr;
        wd_q     <= head.data;
        we_q     <= 1'b1;
        we_sec_q <= 1'b1;
      end else begin
        we_q     <= 1'b0;
        we_sec_q <= 1'b0;
      end

      if (bus.pri_valid && stall_c) err_q <= 1'b1;
    end
  end

  assign bus.sec_ready = sec_ready_c;
  assign bus.stall     = stall_c;
  assign bus.busy_mask = busy_c;
  assign bus.W         = w_q;
  assign bus.WD        = wd_q;
  assign bus.WE        = we_q;
  assign bus.err       = err_q;

`ifdef WB_STATS_EN
  localparam int unsigned SW1 = SW + 1;

  logic [SW-1:0] stat_stall_q;
  logic [SW-1:0] stat_kill_q;
  logic [CW-1:0] kill_cnt;
  logic [SW:0]   kill_sum;

  // Number of entries killed this cycle, added with saturation.
  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      kill_cnt = kill_cnt + CW'(kill_vec[i]);
    end
    kill_sum = {1'b0, stat_kill_q} + SW1'(kill_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_q <= '0;
      stat_kill_q  <= '0;
    end else begin
      if (stall_c && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + SW'(1);
      stat_kill_q <= kill_sum[SW] ? '1 : kill_sum[SW-1:0];
    end
  end

  assign bus.stat_stall = stat_stall_q;
  assign bus.stat_kill  = stat_kill_q;
`else
  assign bus.stat_stall = SW'(0);
  assign bus.stat_kill  = SW'(0);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter (DEPTH=4, MAX_WAIT=8). Expected write-port
// events are queued with their cycle number when stimulus is issued; a
// negedge monitor matches every WE against the queue. Status outputs are
// checked directly against hand-computed values.
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

`ifdef WB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          c;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic push_exp(input int c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.c = c;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs; an accepted primary is expected on the port next cycle.
  task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                      input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    @(posedge clk);
    #1;
    bus.pri_valid = pv;
    bus.pri_addr  = pa;
    bus.pri_data  = pd;
    bus.sec_valid = sv;
    bus.sec_addr  = sa;
    bus.sec_data  = sd;
    if (pv && (pa != 5'd0)) push_exp(cyc + 1, pa, pd);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  // Write-port monitor.
  always @(negedge clk) begin
    int idx;
    idx = -1;
    foreach (exp_q[i]) if (exp_q[i].c == cyc) idx = i;
    if (bus.WE === 1'b1) begin
      if (idx < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_we (cycle %0d): got W=%0d WD=%h, expected WE=0", cyc, bus.W, bus.WD);
      end else begin
        chk("we_addr", 32'(bus.W), 32'(exp_q[idx].a));
        chk("we_data", bus.WD, exp_q[idx].d);
        exp_q.delete(idx);
      end
    end else if (idx >= 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_we (cycle %0d): got WE=%b, expected W=%0d WD=%h",
               cyc, bus.WE, exp_q[idx].a, exp_q[idx].d);
      exp_q.delete(idx);
    end
  end

  initial begin
    int c;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.pri_valid = 1'b0;
    bus.pri_addr  = '0;
    bus.pri_data  = '0;
    bus.sec_valid = 1'b0;
    bus.sec_addr  = '0;
    bus.sec_data  = '0;

    // Reset values.
    idle();
    idle();
    @(negedge clk);
    chk("rst_we", 32'(bus.WE), 32'd0);
    chk("rst_w", 32'(bus.W), 32'd0);
    chk("rst_wd", bus.WD, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", bus.busy_mask, 32'd0);
    chk("rst_sec_ready", 32'(bus.sec_ready), 32'd0);
    chk("rst_stat_stall", 32'(bus.stat_stall), 32'd0);
    rst = 1'b0;

    // Primary only; address 0 is dropped and W/WD hold.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    idle();
    @(negedge clk);
    chk("hold_w", 32'(bus.W), 32'd5);
    chk("hold_wd", bus.WD, 32'h1234);

    // Secondary alone: WE two cycles after acceptance, busy for two cycles.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hCAFE);
    c = cyc;
    push_exp(c + 2, 5'd8, 32'hCAFE);
    @(negedge clk);
    chk("sec_ready_idle", 32'(bus.sec_ready), 32'd1);
    idle();
    @(negedge clk);
    chk("busy8_a", bus.busy_mask, 32'h0000_0100);
    idle();
    @(negedge clk);
    chk("busy8_b", bus.busy_mask, 32'h0000_0100);
    idle();
    @(negedge clk);
    chk("busy8_clr", bus.busy_mask, 32'h0);

    // Fill under continuous primary traffic, then drain.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'(1 + k), 32'h1000 + 32'(k), 1'b1, 5'(10 + k), 32'hA0 + 32'(k));
      if (k == 0) c = cyc;
    end
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h2020);
    for (int k = 0; k < 4; k++) push_exp(c + 5 + k, 5'(10 + k), 32'hA0 + 32'(k));
    @(negedge clk);
    chk("full_sec_ready", 32'(bus.sec_ready), 32'd0);
    chk("full_stall", 32'(bus.stall), 32'd1);
    chk("full_busy", bus.busy_mask, 32'h0000_3C00);
    idle();
    @(negedge clk);
    chk("drain_sec_ready", 32'(bus.sec_ready), 32'd1);
    chk("drain_stall", 32'(bus.stall), 32'd0);
    repeat (4) idle();
    @(negedge clk);
    chk("drain_busy", bus.busy_mask, 32'h0);
    chk("drain_err", 32'(bus.err), 32'd0);

    // Starvation: stall after MAX_WAIT waiting cycles, then the head issues.
    do_reset();
    step(1'b1, 5'd2, 32'h2000, 1'b1, 5'd7, 32'h7777);
    c = cyc;
    push_exp(c + 10, 5'd7, 32'h7777);
    for (int k = 1; k <= 8; k++) step(1'b1, 5'd2, 32'h2000 + 32'(k), 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("starve_no_stall", 32'(bus.stall), 32'd0);
    idle();
    @(negedge clk);
    chk("starve_stall", 32'(bus.stall), 32'd1);
    chk("starve_busy", bus.busy_mask, 32'h0000_0080);
    idle();
    @(negedge clk);
    chk("starve_release", 32'(bus.stall), 32'd0);
    chk("stat_stall", 32'(bus.stat_stall), STATS ? 32'd1 : 32'd0);
    chk("starve_err", 32'(bus.err), 32'd0);

    // Kill: a later primary to the same register kills the queued entry.
    do_reset();
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hAAAA);
    step(1'b1, 5'd3, 32'hBBBB, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("kill_busy_before", bus.busy_mask, 32'h0000_0008);
    idle();
    @(negedge clk);
    chk("kill_busy_after", bus.busy_mask, 32'h0);
    chk("stat_kill", 32'(bus.stat_kill), STATS ? 32'd1 : 32'd0);
    idle();
    @(negedge clk);
    chk("kill_empty_ready", 32'(bus.sec_ready), 32'd1);

    // Same-cycle primary does not kill the entry being enqueued.
    step(1'b1, 5'd4, 32'h4000, 1'b1, 5'd4, 32'h4444);
    c = cyc;
    push_exp(c + 2, 5'd4, 32'h4444);
    idle();
    @(negedge clk);
    chk("nokill_busy", bus.busy_mask, 32'h0000_0010);
    idle();
    idle();
    @(negedge clk);
    chk("nokill_stat", 32'(bus.stat_kill), STATS ? 32'd1 : 32'd0);

    // Secondary to r0 is accepted but discarded.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5555);
    @(negedge clk);
    chk("r0_ready", 32'(bus.sec_ready), 32'd1);
    idle();
    @(negedge clk);
    chk("r0_busy", bus.busy_mask, 32'h0);
    idle();

    // Protocol error while stalled, then reset with two entries queued.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'd1, 32'h3000 + 32'(k), 1'b1, 5'(10 + k), 32'hB0 + 32'(k));
      if (k == 0) c = cyc;
    end
    step(1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("proto_stall", 32'(bus.stall), 32'd1);
    chk("proto_err_pre", 32'(bus.err), 32'd0);
    idle();
    push_exp(c + 6, 5'd10, 32'hB0);
    @(negedge clk);
    chk("proto_err", 32'(bus.err), 32'd1);
    chk("proto_still_full", 32'(bus.stall), 32'd1);
    idle();
    push_exp(c + 7, 5'd11, 32'hB1);
    @(negedge clk);
    chk("proto_err_sticky", 32'(bus.err), 32'd1);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", bus.busy_mask, 32'h0000_3800);
    chk("rst_mid_ready", 32'(bus.sec_ready), 32'd0);
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_we", 32'(bus.WE), 32'd0);
    chk("post_rst_err", 32'(bus.err), 32'd0);
    chk("post_rst_busy", bus.busy_mask, 32'h0);
    chk("post_rst_ready", 32'(bus.sec_ready), 32'd1);
    chk("post_rst_w", 32'(bus.W), 32'd0);
    repeat (4) idle();
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
